alarm_buzzer_ctrl: RTL and testbench
====================================

Name: alarm_buzzer_ctrl

Overview:
Consumes the one-cycle alarm-match pulse from the time-count stage and the filtered key pulses from the debounce stage. Drives the piezo buzzer with a gated square-wave tone in a beep-beep-pause pattern. Supports stop, snooze and an auto-timeout. Its `alarm_active` output feeds the system status manager, which uses it to hold the alarming state.

Parameters:
- TONE_HALF, 12_500: tone half-period in clk cycles (2 kHz at 50 MHz).
- BEEP_ON_CYC, 5_000_000: tone-on duration of one beep (100 ms).
- BEEP_OFF_CYC, 5_000_000: gap between beeps inside a burst.
- PAUSE_CYC, 25_000_000: silence after the last beep of a burst (500 ms).
- BEEPS_PER_BURST, 4: number of beeps per burst; must be ≥1.
- TIMEOUT_BURSTS, 60: number of bursts before the alarm self-cancels; must be ≥1.
- SEC_CYC, 50_000_000: clk cycles per second, used for the snooze timebase.
- SNOOZE_SEC, 300: snooze length in seconds.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- alarm_trig  in  1  one-cycle pulse: alarm time reached
- stop_req  in  1  one-cycle filtered key pulse: cancel the alarm
- snooze_req  in  1  one-cycle filtered key pulse: snooze
- buzzer  out  1  registered tone output to the piezo
- alarm_active  out  1  high in any non-IDLE state
- snoozing  out  1  high in SNOOZE
- alarm_done  out  1  one-cycle pulse when ringing ends by stop or timeout

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, all counters 0, buzzer=0, alarm_active=0, snoozing=0, alarm_done=0. rst takes priority over every other input on that edge.
- All outputs are registered. An input sampled at edge N shows its effect on the outputs after edge N+1 (one-cycle latency).
- States: IDLE, BEEP_ON, BEEP_OFF, PAUSE, SNOOZE.
- IDLE:
  - alarm_trig → BEEP_ON; beep count=0, burst count=0.
  - stop_req and snooze_req are ignored.
- BEEP_ON:
  - Stays for exactly BEEP_ON_CYC cycles.
  - buzzer=1 on the first cycle, then toggles every TONE_HALF cycles.
  - On exit: if beep count==BEEPS_PER_BURST-1 → PAUSE, else → BEEP_OFF with beep count+1.
- BEEP_OFF: stays BEEP_OFF_CYC cycles → BEEP_ON.
- PAUSE:
  - Stays PAUSE_CYC cycles, then burst count+1.
  - If burst count reaches TIMEOUT_BURSTS → IDLE and alarm_done=1 for one cycle.
  - Otherwise → BEEP_ON with beep count=0.
- Ringing states (BEEP_ON, BEEP_OFF, PAUSE):
  - stop_req → IDLE and alarm_done pulse.
  - snooze_req → SNOOZE; the snooze counters clear.
- SNOOZE:
  - A cycle prescaler counts to SEC_CYC and increments a second counter.
  - When the second counter reaches SNOOZE_SEC → BEEP_ON with beep and burst counts reset (the timeout restarts).
  - stop_req → IDLE with no alarm_done pulse.
- buzzer is forced to 0 in every state except BEEP_ON. The tone phase restarts on each BEEP_ON entry.
- Simultaneous events:
  - stop_req beats snooze_req.
  - alarm_trig while alarm_active=1 is ignored, with no restart and no count change.
  - alarm_trig together with stop_req in IDLE → the block enters BEEP_ON.
- Counter widths are derived with $clog2 of each parameter. No counter wraps; each counter clears on every state change.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined: SNOOZE state, snooze counters and snooze_req handling exist exactly as described above.
- Undefined:
  - SNOOZE state and its counters are not generated.
  - snooze_req is ignored and snoozing is tied to 0.
  - The ringing states respond only to stop_req and timeout.

Decomposition:
- Shared package clock_pkg holds:
  - the state enum localparams (IDLE=0 … SNOOZE=4);
  - the key-mask constants shared with the status managers.
- One natural sub-module, tone_gen:
  - Inputs: enable, phase-restart.
  - Output: the square wave at TONE_HALF.
  - Instantiated once; the FSM and timers stay in alarm_buzzer_ctrl.

Test Plan:
All scenarios use reduced parameters: TONE_HALF=2, BEEP_ON_CYC=8, BEEP_OFF_CYC=4, PAUSE_CYC=10, BEEPS_PER_BURST=2, TIMEOUT_BURSTS=3, SEC_CYC=5, SNOOZE_SEC=2. One burst is 30 cycles.
- Trigger and timeout: alarm_trig at cycle 0 → alarm_active=1 from cycle 1. buzzer pattern 1,1,0,0 repeating within each 8-cycle BEEP_ON. buzzer=0 for 4 cycles between beeps and for 10 cycles of PAUSE. alarm_done single pulse at cycle 91. alarm_active=0 from cycle 91.
- Stop mid-beep: trig at 0, stop_req at 5 → buzzer=0, alarm_active=0, alarm_done=1 at cycle 6, then idle. A later trig restarts from beep 0.
- Snooze: trig at 0, snooze_req at 12 → snoozing=1 and buzzer=0 from 13. Re-ring (BEEP_ON, snoozing=0) at cycle 23. The full 3 bursts follow, ending with alarm_done at 113.
- Priority: stop_req and snooze_req in the same cycle while ringing → IDLE plus alarm_done. alarm_trig during ringing → the pattern is unchanged.
- Reset: rst asserted in BEEP_ON → all outputs 0 on the next cycle. rst held while alarm_trig pulses → stays IDLE.
- Macro off: with ALARM_SNOOZE_EN undefined, snooze_req at 12 → no effect; snoozing stays 0 and timeout occurs at 91.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clock_pkg
// Brief   : Shared state encodings, key masks and sizing helpers for the
//           alarm-clock control blocks.
// Revision: 1.0 - initial release
// ============================================================================
package clock_pkg;

   typedef logic [2:0] state_t;

   localparam state_t c_st_idle     = 3'd0;
   localparam state_t c_st_beep_on  = 3'd1;
   localparam state_t c_st_beep_off = 3'd2;
   localparam state_t c_st_pause    = 3'd3;
   localparam state_t c_st_snooze   = 3'd4;

   // Debounced key bit positions, shared with the status managers.
   localparam logic [3:0] c_key_mode   = 4'b0001;
   localparam logic [3:0] c_key_set    = 4'b0010;
   localparam logic [3:0] c_key_stop   = 4'b0100;
   localparam logic [3:0] c_key_snooze = 4'b1000;

   // Width of a counter that runs 0 .. n-1 (never narrower than one bit).
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_buzzer_ctrl_tone_gen.sv
`default_nettype none
// ============================================================================
// Module  : tone_gen
// Brief   : Registered square wave of half-period TONE_HALF; starts high on
//           restart and is held low whenever enable is low.
// Revision: 1.0 - initial release
// ============================================================================
module tone_gen
   import clock_pkg::*;
#(
   parameter int TONE_HALF = 12_500
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic tone
);

   localparam int                 c_cnt_w     = cnt_w(TONE_HALF);
   localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(TONE_HALF - 1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         r_cnt <= '0;
         tone  <= 1'b0;
      end else if (restart) begin
         r_cnt <= '0;
         tone  <= 1'b1;
      end else if (r_cnt == c_half_last) begin
         r_cnt <= '0;
         tone  <= ~tone;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alarm_buzzer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alarm_buzzer_ctrl
// Brief   : Beep-beep-pause buzzer driver with stop, auto-timeout and optional
//           snooze (enabled by defining ALARM_SNOOZE_EN).
// Revision: 1.0 - initial release
// ============================================================================
module alarm_buzzer_ctrl
   import clock_pkg::*;
#(
   parameter int TONE_HALF       = 12_500,
   parameter int BEEP_ON_CYC     = 5_000_000,
   parameter int BEEP_OFF_CYC    = 5_000_000,
   parameter int PAUSE_CYC       = 25_000_000,
   parameter int BEEPS_PER_BURST = 4,
   parameter int TIMEOUT_BURSTS  = 60,
   parameter int SEC_CYC         = 50_000_000,
   parameter int SNOOZE_SEC      = 300
) (
   input  logic clk,
   input  logic rst,
   input  logic alarm_trig,
   input  logic stop_req,
   input  logic snooze_req,
   output logic buzzer,
   output logic alarm_active,
   output logic snoozing,
   output logic alarm_done
);

   localparam int c_tmr_w   = cnt_w(max3(BEEP_ON_CYC, BEEP_OFF_CYC, PAUSE_CYC));
   localparam int c_beep_w  = cnt_w(BEEPS_PER_BURST);
   localparam int c_burst_w = cnt_w(TIMEOUT_BURSTS);

   localparam logic [c_tmr_w-1:0]   c_on_last    = c_tmr_w'(BEEP_ON_CYC - 1);
   localparam logic [c_tmr_w-1:0]   c_off_last   = c_tmr_w'(BEEP_OFF_CYC - 1);
   localparam logic [c_tmr_w-1:0]   c_pause_last = c_tmr_w'(PAUSE_CYC - 1);
   localparam logic [c_beep_w-1:0]  c_beep_last  = c_beep_w'(BEEPS_PER_BURST - 1);
   localparam logic [c_burst_w-1:0] c_burst_last = c_burst_w'(TIMEOUT_BURSTS - 1);

   state_t               r_state;
   state_t               w_nxt;
   logic                 w_done;
   logic                 w_ringing;
   logic                 w_state_chg;
   logic [c_tmr_w-1:0]   r_tmr;
   logic [c_beep_w-1:0]  r_beep;
   logic [c_burst_w-1:0] r_burst;

`ifdef ALARM_SNOOZE_EN
   localparam int                 c_pre_w    = cnt_w(SEC_CYC);
   localparam int                 c_sec_w    = cnt_w(SNOOZE_SEC);
   localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SEC_CYC - 1);
   localparam logic [c_sec_w-1:0] c_sec_last = c_sec_w'(SNOOZE_SEC - 1);

   logic [c_pre_w-1:0] r_pre;
   logic [c_sec_w-1:0] r_sec;
`else
   localparam int c_unused_snooze_cfg = SEC_CYC + SNOOZE_SEC;
   logic          w_unused_snooze_req;
   assign w_unused_snooze_req = snooze_req;
`endif

   assign w_ringing   = (r_state == c_st_beep_on) || (r_state == c_st_beep_off) ||
                        (r_state == c_st_pause);
   assign w_state_chg = (w_nxt != r_state);

   always_comb begin
      w_nxt  = r_state;
      w_done = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (alarm_trig) w_nxt = c_st_beep_on;
         end
         c_st_beep_on: begin
            if (r_tmr == c_on_last)
               w_nxt = (r_beep == c_beep_last) ? c_st_pause : c_st_beep_off;
         end
         c_st_beep_off: begin
            if (r_tmr == c_off_last) w_nxt = c_st_beep_on;
         end
         c_st_pause: begin
            if (r_tmr == c_pause_last) begin
               if (r_burst == c_burst_last) begin
                  w_nxt  = c_st_idle;
                  w_done = 1'b1;
               end else begin
                  w_nxt = c_st_beep_on;
               end
            end
         end
`ifdef ALARM_SNOOZE_EN
         c_st_snooze: begin
            if (stop_req)
               w_nxt = c_st_idle;
            else if ((r_pre == c_pre_last) && (r_sec == c_sec_last))
               w_nxt = c_st_beep_on;
         end
`endif
         default: w_nxt = c_st_idle;
      endcase

      // Key requests override the pattern timers; stop wins over snooze.
      if (w_ringing) begin
         if (stop_req) begin
            w_nxt  = c_st_idle;
            w_done = 1'b1;
         end
`ifdef ALARM_SNOOZE_EN
         else if (snooze_req) begin
            w_nxt  = c_st_snooze;
            w_done = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= c_st_idle;
         r_tmr        <= '0;
         r_beep       <= '0;
         r_burst      <= '0;
         alarm_active <= 1'b0;
         snoozing     <= 1'b0;
         alarm_done   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         r_pre        <= '0;
         r_sec        <= '0;
`endif
      end else begin
         r_state      <= w_nxt;
         alarm_active <= (w_nxt != c_st_idle);
         alarm_done   <= w_done;

         if (w_state_chg || !w_ringing)
            r_tmr <= '0;
         else
            r_tmr <= r_tmr + 1'b1;

         // Beep index survives BEEP_OFF; every other entry to BEEP_ON starts a new burst.
         if (w_state_chg && (w_nxt == c_st_beep_on) && (r_state != c_st_beep_off))
            r_beep <= '0;
         else if ((r_state == c_st_beep_on) && (w_nxt == c_st_beep_off))
            r_beep <= r_beep + 1'b1;

         if ((w_nxt == c_st_beep_on) && !w_ringing)
            r_burst <= '0;
         else if ((r_state == c_st_pause) && (w_nxt == c_st_beep_on))
            r_burst <= r_burst + 1'b1;

`ifdef ALARM_SNOOZE_EN
         snoozing <= (w_nxt == c_st_snooze);
         if (w_state_chg || (w_nxt != c_st_snooze)) begin
            r_pre <= '0;
            r_sec <= '0;
         end else if (r_pre == c_pre_last) begin
            r_pre <= '0;
            r_sec <= r_sec + 1'b1;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
`else
         snoozing <= 1'b0;
`endif
      end
   end

   tone_gen #(
      .TONE_HALF (TONE_HALF)
   ) u_tone_gen (
      .clk     (clk),
      .rst     (rst),
      .enable  (w_nxt == c_st_beep_on),
      .restart (r_state != c_st_beep_on),
      .tone    (buzzer)
   );

endmodule
`default_nettype wire

// File: tb/tb_alarm_buzzer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alarm_buzzer_ctrl
// Brief   : Scoreboard bench: a timeline model predicts every output cycle and
//           a negedge monitor compares the DUT against the queued prediction.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alarm_buzzer_ctrl;

   localparam int TONE_HALF       = 2;
   localparam int BEEP_ON_CYC     = 8;
   localparam int BEEP_OFF_CYC    = 4;
   localparam int PAUSE_CYC       = 10;
   localparam int BEEPS_PER_BURST = 2;
   localparam int TIMEOUT_BURSTS  = 3;
   localparam int SEC_CYC         = 5;
   localparam int SNOOZE_SEC      = 2;

   localparam int BEEP_SLOT = BEEP_ON_CYC + BEEP_OFF_CYC;
   localparam int BURST_LEN = BEEPS_PER_BURST * BEEP_SLOT - BEEP_OFF_CYC + PAUSE_CYC;
   localparam int RING_LEN  = TIMEOUT_BURSTS * BURST_LEN;
   localparam int SNZ_LEN   = SEC_CYC * SNOOZE_SEC;

`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_RING = 1;
   localparam int M_SNZ  = 2;

   typedef struct packed {
      logic buzzer;
      logic active;
      logic snoozing;
      logic done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic alarm_trig = 1'b0;
   logic stop_req = 1'b0;
   logic snooze_req = 1'b0;
   logic buzzer;
   logic alarm_active;
   logic snoozing;
   logic alarm_done;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   m_mode   = M_IDLE;
   int   m_pos    = 0;
   int   m_snz    = 0;

   always #5 clk = ~clk;

   alarm_buzzer_ctrl #(
      .TONE_HALF       (TONE_HALF),
      .BEEP_ON_CYC     (BEEP_ON_CYC),
      .BEEP_OFF_CYC    (BEEP_OFF_CYC),
      .PAUSE_CYC       (PAUSE_CYC),
      .BEEPS_PER_BURST (BEEPS_PER_BURST),
      .TIMEOUT_BURSTS  (TIMEOUT_BURSTS),
      .SEC_CYC         (SEC_CYC),
      .SNOOZE_SEC      (SNOOZE_SEC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .alarm_trig   (alarm_trig),
      .stop_req     (stop_req),
      .snooze_req   (snooze_req),
      .buzzer       (buzzer),
      .alarm_active (alarm_active),
      .snoozing     (snoozing),
      .alarm_done   (alarm_done)
   );

   // Tone level at position pos cycles into a ringing session.
   function automatic logic tone_at(input int pos);
      int o;
      int r;
      o = pos % BURST_LEN;
      if (o >= BEEPS_PER_BURST * BEEP_SLOT - BEEP_OFF_CYC) return 1'b0;
      r = o % BEEP_SLOT;
      if (r >= BEEP_ON_CYC) return 1'b0;
      return ((r / TONE_HALF) % 2) == 0;
   endfunction

   task automatic model_step(input logic r, input logic t, input logic st, input logic sz);
      exp_t e;
      e = '0;
      if (r) begin
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: if (t) begin
               m_mode = M_RING;
               m_pos  = 0;
            end
            M_RING: begin
               if (st) begin
                  m_mode = M_IDLE;
                  e.done = 1'b1;
               end else if (SNZ_EN && sz) begin
                  m_mode = M_SNZ;
                  m_snz  = 0;
               end else begin
                  m_pos++;
                  if (m_pos == RING_LEN) begin
                     m_mode = M_IDLE;
                     e.done = 1'b1;
                  end
               end
            end
            default: begin
               if (st) begin
                  m_mode = M_IDLE;
               end else begin
                  m_snz++;
                  if (m_snz == SNZ_LEN) begin
                     m_mode = M_RING;
                     m_pos  = 0;
                  end
               end
            end
         endcase
      end
      e.active   = (m_mode != M_IDLE);
      e.snoozing = (m_mode == M_SNZ);
      e.buzzer   = (m_mode == M_RING) && tone_at(m_pos);
      q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic t, input logic st, input logic sz);
      rst        = r;
      alarm_trig = t;
      stop_req   = st;
      snooze_req = sz;
      @(posedge clk);
      model_step(r, t, st, sz);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check_bit("buzzer",       buzzer,       e.buzzer);
         check_bit("alarm_active", alarm_active, e.active);
         check_bit("snoozing",     snoozing,     e.snoozing);
         check_bit("alarm_done",   alarm_done,   e.done);
      end
   end

   initial begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      // Full ring to timeout.
      cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(100);
      // Stop mid-beep, then a fresh trigger.
      cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(4); cyc(1'b0, 1'b0, 1'b1, 1'b0); idle(5);
      cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(40); cyc(1'b0, 1'b0, 1'b1, 1'b0); idle(3);
      // Snooze during the first gap, then ring to timeout.
      cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(11); cyc(1'b0, 1'b0, 1'b0, 1'b1); idle(120);
      // Stop and snooze together; re-trigger while ringing.
      cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(6); cyc(1'b0, 1'b0, 1'b1, 1'b1); idle(3);
      cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(10); cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(30);
      cyc(1'b0, 1'b0, 1'b1, 1'b0); idle(2);
      // Stop in snooze gives no done pulse.
      cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(3); cyc(1'b0, 1'b0, 1'b0, 1'b1); idle(4);
      cyc(1'b0, 1'b0, 1'b1, 1'b0); idle(3);
      // Trigger with stop in idle, reset in BEEP_ON, trigger held off by reset.
      cyc(1'b0, 1'b1, 1'b1, 1'b0); idle(5);
      cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0, 1'b0); idle(5);
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 149) == 0), ($urandom_range(0, 89) == 0));
      end
      idle(2);
      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
